serial_adder: RTL and testbench

Bit-serial adder/subtractor that drives the team's FA cell one bit per clock. It adds two WIDTH-bit operands LSB-first and returns the sum, carry-out and signed-overflow flag. The block sits as the sequential stage around the single full adder: it sequences operands into the FA and captures what the FA produces. It is intended for area-constrained datapaths where one FA replaces a WIDTH-bit ripple chain.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 140 ++++++++++++++
 tb/tb_serial_adder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

   localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell; purely combinational, zero latency, no flow control.
module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract around one FA cell, LSB first; result valid WIDTH cycles after accept.
// Result is held in DONE until out_ready; no new operands are taken until the result is consumed.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic fa_s;
   logic fa_c;

   serial_adder_fa u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_c)
   );

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_sh_d    = res_sh_q;
      c_d         = c_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;

      case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid) begin
               // Subtraction is a + ~b + 1, so the inversion and the +1 happen at load.
               a_sh_d     = a;
               b_sh_d     = sub ? ~b : b;
               c_d        = sub ? 1'b1 : cin;
               cnt_d      = '0;
               res_sh_d   = '0;
               in_ready_d = 1'b0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            c_d      = fa_c;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               // c_q is the carry into the MSB, fa_c the carry out of it.
               sum_d       = res_sh_d;
               cout_d      = fa_c;
               ovf_d       = c_q ^ fa_c;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_sh_q    <= '0;
         c_q         <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_sh_q    <= res_sh_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {ovf,cout,sum} queued at acceptance, checked at out_valid.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           pass_cnt = 0;
   int           total_cnt = 0;
   logic [W+1:0] exp_q[$];
   int           acc_cyc = 0;
   logic         acc_ok = 1'b0;

   // Reference: {ovf, cout, sum} from a full-width add and the sign rule.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         v;
      bb   = ms ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
      v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
      return {v, full[W], full[W-1:0]};
   endfunction

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
      a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1; acc_ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (in_ready) begin
            acc_ok = 1'b1;
            @(posedge clk); #1;
            acc_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (acc_ok) exp_q.push_back(model(ia, ib, ic, is));
   endtask

   task automatic wait_valid(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic [W+1:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      total_cnt++;
      if ({in_ready, out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}})
         $display("FAIL reset_outputs got=%h exp=%h", {in_ready, out_valid, ovf, cout, sum},
                  {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
      else pass_cnt++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      logic ok;
      logic [W+1:0] e;
      issue(8'h5A, 8'h3C, 1'b0, 1'b0);
      wait_valid(ok);
      total_cnt++;
      if (!ok || (cyc - acc_cyc) != W)
         $display("FAIL add_latency got=%0d exp=%0d valid=%0b", cyc - acc_cyc, W, ok);
      else pass_cnt++;
      e = pop_exp();
      total_cnt++;
      if ({ovf, cout, sum} !== e) $display("FAIL add_result got=%h exp=%h", {ovf, cout, sum}, e);
      else pass_cnt++;
      total_cnt++;
      if ({ovf, cout, sum} !== {1'b1, 1'b0, 8'h96})
         $display("FAIL add_literal got=%h exp=%h", {ovf, cout, sum}, {1'b1, 1'b0, 8'h96});
      else pass_cnt++;
      consume();
      total_cnt++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL add_release got=%b exp=10", {in_ready, out_valid});
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [W-1:0] ta[2] = '{8'hFF, 8'h7F};
      logic [W-1:0] tb[2] = '{8'h01, 8'h00};
      logic         tc[2] = '{1'b0, 1'b1};
      logic ok;
      logic [W+1:0] e;
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], tb[i], tc[i], 1'b0);
         wait_valid(ok);
         e = pop_exp();
         total_cnt++;
         if (!ok || {ovf, cout, sum} !== e)
            $display("FAIL wrap_%0d got=%h exp=%h valid=%0b", i, {ovf, cout, sum}, e, ok);
         else pass_cnt++;
         consume();
      end
   endtask

   task automatic test_sub();
      logic ok;
      logic [W+1:0] e;
      for (int i = 0; i < 2; i++) begin
         issue(8'h10, 8'h20, (i == 0), 1'b1);
         wait_valid(ok);
         e = pop_exp();
         total_cnt++;
         if (!ok || {ovf, cout, sum} !== e || e !== {1'b0, 1'b0, 8'hF0})
            $display("FAIL sub_cin%0d got=%h exp=%h valid=%0b", (i == 0), {ovf, cout, sum}, e, ok);
         else pass_cnt++;
         consume();
      end
   endtask

   task automatic test_backpressure();
      logic ok;
      logic [W+1:0] e;
      int c0;
      issue(8'hA3, 8'h5C, 1'b1, 1'b0);
      wait_valid(ok);
      e = pop_exp();
      total_cnt++;
      if (!ok || {ovf, cout, sum} !== e)
         $display("FAIL bp_result got=%h exp=%h valid=%0b", {ovf, cout, sum}, e, ok);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         @(posedge clk); #1;
         total_cnt++;
         if ({in_ready, out_valid, ovf, cout, sum} !== {1'b0, 1'b1, e})
            $display("FAIL bp_hold_%0d got=%h exp=%h", i, {in_ready, out_valid, ovf, cout, sum},
                     {1'b0, 1'b1, e});
         else pass_cnt++;
      end
      in_valid = 1'b0;
      consume();
      total_cnt++;
      if ({in_ready, out_valid, ovf, cout, sum} !== {1'b1, 1'b0, e})
         $display("FAIL bp_idle got=%h exp=%h", {in_ready, out_valid, ovf, cout, sum}, {1'b1, 1'b0, e});
      else pass_cnt++;
      c0 = cyc;
      issue(8'h22, 8'h11, 1'b0, 1'b0);
      total_cnt++;
      if (!acc_ok || acc_cyc != c0 + 1)
         $display("FAIL bp_accept got=%0d exp=%0d ok=%0b", acc_cyc, c0 + 1, acc_ok);
      else pass_cnt++;
      wait_valid(ok);
      e = pop_exp();
      total_cnt++;
      if (!ok || {ovf, cout, sum} !== e)
         $display("FAIL bp_next got=%h exp=%h valid=%0b", {ovf, cout, sum}, e, ok);
      else pass_cnt++;
      consume();
   endtask

   task automatic test_reset_mid_op();
      logic ok;
      logic [W+1:0] e;
      issue(8'h0F, 8'h01, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      total_cnt++;
      if ({in_ready, out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}})
         $display("FAIL midop_reset got=%h exp=%h", {in_ready, out_valid, ovf, cout, sum},
                  {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
      else pass_cnt++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(8'h01, 8'h01, 1'b0, 1'b0);
      wait_valid(ok);
      e = pop_exp();
      total_cnt++;
      if (!ok || {ovf, cout, sum} !== e || sum !== 8'h02)
         $display("FAIL midop_fresh got=%h exp=%h valid=%0b", {ovf, cout, sum}, e, ok);
      else pass_cnt++;
      consume();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ta[3] = '{8'hC8, 8'h40, 8'h00};
      logic [W-1:0] tb[3] = '{8'h64, 8'h40, 8'h01};
      logic         tc[3] = '{1'b0, 1'b1, 1'b0};
      logic         ts[3] = '{1'b0, 1'b0, 1'b1};
      int acc_t[3];
      int idx = 0;
      int nres = 0;
      logic take;
      logic [W+1:0] e;
      out_ready = 1'b1;
      a = ta[0]; b = tb[0]; cin = tc[0]; sub = ts[0]; in_valid = 1'b1;
      for (int n = 0; n < 100 && nres < 3; n++) begin
         take = in_valid && in_ready;
         @(posedge clk); #1;
         if (take) begin
            acc_t[idx] = cyc;
            exp_q.push_back(model(ta[idx], tb[idx], tc[idx], ts[idx]));
            idx++;
            if (idx < 3) begin
               a = ta[idx]; b = tb[idx]; cin = tc[idx]; sub = ts[idx];
            end else in_valid = 1'b0;
         end
         if (out_valid) begin
            e = pop_exp();
            total_cnt++;
            if ({ovf, cout, sum} !== e) $display("FAIL b2b_result_%0d got=%h exp=%h", nres, {ovf, cout, sum}, e);
            else pass_cnt++;
            nres++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total_cnt++;
      if (nres != 3 || idx != 3) $display("FAIL b2b_timeout got=%0d results exp=3", nres);
      else pass_cnt++;
      for (int i = 1; i < 3; i++) begin
         total_cnt++;
         if (idx != 3 || acc_t[i] - acc_t[i-1] != W + 2)
            $display("FAIL b2b_gap_%0d got=%0d exp=%0d", i, acc_t[i] - acc_t[i-1], W + 2);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_wrap();
      test_sub();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
